// File: rtl/vec_stim_gen_if.sv
// Lane bus between the stimulus generator and the downstream register stage:
// forward vector lanes plus the lanes returned after the downstream latency.
interface vec_stim_gen_if #(
    parameter int SMALL_W = 2,
    parameter int QUAD_W  = 40,
    parameter int WIDE_W  = 70
);
    logic [SMALL_W-1:0] out_small;
    logic [QUAD_W-1:0]  out_quad;
    logic [WIDE_W-1:0]  out_wide;
    logic               vec_valid;
    logic [SMALL_W-1:0] ret_small;
    logic [QUAD_W-1:0]  ret_quad;
    logic [WIDE_W-1:0]  ret_wide;

    modport master (
        output out_small, out_quad, out_wide, vec_valid,
        input  ret_small, ret_quad, ret_wide
    );

    modport slave (
        input  out_small, out_quad, out_wide, vec_valid,
        output ret_small, ret_quad, ret_wide
    );
endinterface

// File: rtl/vec_stim_gen.sv
// LFSR stimulus generator for the 3-lane register top; checks returned lanes after LAT cycles.
// Optional saturating failure counter enabled by defining VEC_STIM_ERR_CNT_EN.
module vec_stim_gen #(
    parameter int                SMALL_W = 2,
    parameter int                QUAD_W  = 40,
    parameter int                WIDE_W  = 70,
    parameter int                CNT_W   = 16,
    parameter int                LAT     = 1,
    parameter logic [WIDE_W-1:0] SEED    = 70'h2A_5A5A_5A5A_5A5A_5A5A
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_seed_load,
    input  logic [WIDE_W-1:0]  i_seed_in,
    input  logic               i_start,
    input  logic [CNT_W-1:0]   i_num_vectors,
    vec_stim_gen_if.master     bus,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_mismatch,
    output logic [CNT_W-1:0]   o_err_count
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                       r_state, w_next;
    logic [WIDE_W-1:0]            r_lfsr, w_lfsr_nxt;
    logic [WIDE_W-1:0]            r_out_wide;
    logic                         r_vld;
    logic [CNT_W-1:0]             r_cnt;
    logic [3:0]                   r_drain;
    logic [LAT-1:0]               r_vld_pipe;
    logic [LAT-1:0][WIDE_W-1:0]   r_exp_pipe;
    logic                         r_mismatch;
    logic                         w_start_acc;
    logic                         w_fail;
    logic [WIDE_W-1:0]            w_exp;

    // seed_load takes priority over start in the same cycle
    assign w_start_acc = (r_state == S_IDLE) && i_start && !i_seed_load;
    assign w_lfsr_nxt  = {r_lfsr[WIDE_W-2:0], r_lfsr[69] ^ r_lfsr[68] ^ r_lfsr[54] ^ r_lfsr[53]};
    assign w_exp       = r_exp_pipe[LAT-1];
    assign w_fail      = r_vld_pipe[LAT-1] &&
                         ((bus.ret_wide  != w_exp) ||
                          (bus.ret_quad  != w_exp[QUAD_W-1:0]) ||
                          (bus.ret_small != w_exp[SMALL_W-1:0]));

    assign bus.out_wide  = r_out_wide;
    assign bus.out_quad  = r_out_wide[QUAD_W-1:0];
    assign bus.out_small = r_out_wide[SMALL_W-1:0];
    assign bus.vec_valid = r_vld;
    assign o_mismatch    = r_mismatch;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_acc) w_next = (i_num_vectors != '0) ? S_RUN : S_DONE;
            S_RUN:   if (r_cnt == CNT_W'(1)) w_next = S_DRAIN;
            // DRAIN spans the last visible vector plus LAT return cycles
            S_DRAIN: if (r_drain == 4'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == S_RUN) || (r_state == S_DRAIN);
        o_done = (r_state == S_DONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_lfsr     <= SEED;
            r_out_wide <= '0;
            r_vld      <= 1'b0;
            r_cnt      <= '0;
            r_drain    <= '0;
            r_vld_pipe <= '0;
            r_exp_pipe <= '0;
            r_mismatch <= 1'b0;
        end else begin
            r_vld <= (r_state == S_RUN);
            if (r_state == S_IDLE && i_seed_load)
                r_lfsr <= (i_seed_in == '0) ? SEED : i_seed_in;
            if (r_state == S_RUN) begin
                r_out_wide <= r_lfsr;
                r_lfsr     <= w_lfsr_nxt;
                r_cnt      <= r_cnt - 1'b1;
                r_drain    <= 4'(LAT);
            end else if (r_state == S_DRAIN) begin
                r_drain    <= r_drain - 1'b1;
            end
            if (w_start_acc) begin
                r_cnt      <= i_num_vectors;
                r_mismatch <= 1'b0;
            end else if (w_fail) begin
                r_mismatch <= 1'b1;
            end
            r_vld_pipe[0] <= r_vld;
            r_exp_pipe[0] <= r_out_wide;
            for (int i = 1; i < LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_exp_pipe[i] <= r_exp_pipe[i-1];
            end
        end
    end

`ifdef VEC_STIM_ERR_CNT_EN
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset)                         r_err_cnt <= '0;
        else if (w_start_acc)                r_err_cnt <= '0;
        else if (w_fail && r_err_cnt != '1)  r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign o_err_count = r_err_cnt;
`else
    assign o_err_count = '0;
`endif
endmodule

// File: tb/tb_vec_stim_gen.sv
// Directed bench for vec_stim_gen with a 1-cycle register model as the downstream stage.
module tb_vec_stim_gen;
    localparam int SW = 2;
    localparam int QW = 40;
    localparam int WW = 70;
    localparam int CW = 16;
    localparam logic [WW-1:0] SEED = 70'h2A_5A5A_5A5A_5A5A_5A5A;
`ifdef VEC_STIM_ERR_CNT_EN
    localparam logic [WW-1:0] EXP_ERR = 70'd1;
`else
    localparam logic [WW-1:0] EXP_ERR = 70'd0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          seed_load = 1'b0;
    logic [WW-1:0] seed_in = '0;
    logic          start = 1'b0;
    logic [CW-1:0] num_vectors = '0;
    logic [SW-1:0] flip_mask = '0;
    logic          busy, done, mismatch;
    logic [CW-1:0] err_count;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [WW-1:0] vecs [16];
    logic [WW-1:0] sq [10];
    int            nvec, ndone, done_at, busy_cnt;
    logic          mis_done;
    logic [CW-1:0] err_done;
    logic [QW-1:0] q0;
    logic [SW-1:0] s0;

    vec_stim_gen_if #(.SMALL_W(SW), .QUAD_W(QW), .WIDE_W(WW)) bus ();

    vec_stim_gen #(.SMALL_W(SW), .QUAD_W(QW), .WIDE_W(WW), .CNT_W(CW), .LAT(1), .SEED(SEED)) dut (
        .i_clk(clk), .i_reset(reset), .i_seed_load(seed_load), .i_seed_in(seed_in),
        .i_start(start), .i_num_vectors(num_vectors), .bus(bus),
        .o_busy(busy), .o_done(done), .o_mismatch(mismatch), .o_err_count(err_count)
    );

    always #5 clk = ~clk;

    // downstream register stage; flip_mask corrupts the small lane on demand
    always @(posedge clk) begin
        bus.ret_wide  <= bus.out_wide;
        bus.ret_quad  <= bus.out_quad;
        bus.ret_small <= bus.out_small ^ flip_mask;
    end

    function automatic logic [WW-1:0] lfsr_nx(input logic [WW-1:0] s);
        return {s[WW-2:0], s[69] ^ s[68] ^ s[54] ^ s[53]};
    endfunction

    task automatic chk(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input int pulse_at, input int flip_at, input int cycles);
        num_vectors = CW'(n);
        start = 1'b1;
        nvec = 0; ndone = 0; done_at = -1; busy_cnt = 0;
        mis_done = 1'b0; err_done = '0; q0 = '0; s0 = '0;
        for (int c = 0; c < cycles; c++) begin
            tick();
            start = (c == pulse_at);
            flip_mask = '0;
            if (bus.vec_valid) begin
                if (nvec == 0) begin
                    q0 = bus.out_quad;
                    s0 = bus.out_small;
                end
                if (nvec < 16) vecs[nvec] = bus.out_wide;
                if (nvec == flip_at) flip_mask = '1;
                nvec++;
            end
            if (busy) busy_cnt++;
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at  = c;
                    mis_done = mismatch;
                    err_done = err_count;
                end
            end
        end
        start = 1'b0;
        flip_mask = '0;
    endtask

    initial begin
        sq[0] = SEED;
        for (int i = 1; i < 10; i++) sq[i] = lfsr_nx(sq[i-1]);

        tick(); tick();
        chk("rst_valid", WW'(bus.vec_valid), '0);
        chk("rst_wide", bus.out_wide, '0);
        chk("rst_busy", WW'(busy), '0);
        chk("rst_done", WW'(done), '0);
        chk("rst_mis", WW'(mismatch), '0);
        chk("rst_err", WW'(err_count), '0);
        reset = 1'b0;

        // seed 1, three clean vectors
        seed_load = 1'b1; seed_in = 70'd1;
        tick();
        seed_load = 1'b0;
        run(3, -1, -1, 10);
        chk("t1_nvec", WW'(nvec), WW'(3));
        chk("t1_v0", vecs[0], 70'h1);
        chk("t1_v1", vecs[1], 70'h2);
        chk("t1_v2", vecs[2], 70'h4);
        chk("t1_done_at", WW'(done_at), WW'(5));
        chk("t1_ndone", WW'(ndone), WW'(1));
        chk("t1_busy_cnt", WW'(busy_cnt), WW'(5));
        chk("t1_mis", WW'(mis_done), '0);
        chk("t1_err", WW'(err_done), '0);

        // zero seed falls back to SEED; corrupt small lane of 2nd vector
        seed_load = 1'b1; seed_in = '0;
        tick();
        seed_load = 1'b0;
        run(4, -1, 1, 12);
        chk("t2_nvec", WW'(nvec), WW'(4));
        chk("t2_v0", vecs[0], SEED);
        chk("t2_q0", WW'(q0), 70'h5A_5A5A_5A5A);
        chk("t2_s0", WW'(s0), 70'h2);
        chk("t2_v3", vecs[3], sq[3]);
        chk("t2_mis", WW'(mis_done), 70'd1);
        chk("t2_err", WW'(err_done), EXP_ERR);

        // zero-length run
        run(0, -1, -1, 5);
        chk("t3_nvec", WW'(nvec), '0);
        chk("t3_done_at", WW'(done_at), '0);
        chk("t3_ndone", WW'(ndone), WW'(1));
        chk("t3_busy_cnt", WW'(busy_cnt), '0);

        // reset after two of ten vectors; sequence had continued from SEED+4
        num_vectors = CW'(10); start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        chk("t4_mid_valid", WW'(bus.vec_valid), 70'd1);
        chk("t4_mid_wide", bus.out_wide, sq[5]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4_rst_wide", bus.out_wide, '0);
        chk("t4_rst_quad", WW'(bus.out_quad), '0);
        chk("t4_rst_small", WW'(bus.out_small), '0);
        chk("t4_rst_valid", WW'(bus.vec_valid), '0);
        chk("t4_rst_busy", WW'(busy), '0);
        chk("t4_rst_done", WW'(done), '0);
        chk("t4_rst_mis", WW'(mismatch), '0);
        chk("t4_rst_err", WW'(err_count), '0);
        run(3, -1, -1, 10);
        chk("t4_v0", vecs[0], sq[0]);
        chk("t4_v1", vecs[1], sq[1]);
        chk("t4_v2", vecs[2], sq[2]);
        chk("t4_mis", WW'(mis_done), '0);

        // start re-pulsed mid-run is ignored; sequence persists across runs
        run(5, 2, -1, 14);
        chk("t5_nvec", WW'(nvec), WW'(5));
        chk("t5_ndone", WW'(ndone), WW'(1));
        chk("t5_done_at", WW'(done_at), WW'(7));
        chk("t5_v0", vecs[0], sq[3]);
        chk("t5_v4", vecs[4], sq[7]);

        // seed_load and start together: seed taken, start dropped
        seed_load = 1'b1; seed_in = 70'd1; start = 1'b1; num_vectors = CW'(2);
        tick();
        seed_load = 1'b0; start = 1'b0;
        chk("t6_busy0", WW'(busy), '0);
        tick();
        chk("t6_valid", WW'(bus.vec_valid), '0);
        run(1, -1, -1, 8);
        chk("t6_nvec", WW'(nvec), WW'(1));
        chk("t6_v0", vecs[0], 70'h1);
        chk("t6_done_at", WW'(done_at), WW'(3));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vec_stim_gen.md
Name: vec_stim_gen

Overview:
Upstream stimulus stage for the three-lane register top (2/40/70-bit lanes). It produces one LFSR-derived vector per cycle on all three lanes and captures the lane values returned by the downstream stage after a fixed latency. It compares each returned value against the vector it sent and reports pass/fail. Runs are self-contained: seed, start, then N vectors, drain, done.

Parameters:
SMALL_W, 2, width of small lane
QUAD_W, 40, width of quad lane
WIDE_W, 70, width of wide lane and of LFSR state
CNT_W, 16, width of vector counter and error counter
LAT, 1, downstream latency in cycles from out_* to ret_*; legal range 1..8
SEED, 70'h2A_5A5A_5A5A_5A5A_5A5A, reset and fallback LFSR seed (nonzero)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high
seed_load  in  1  load seed_in into LFSR (honoured only in IDLE)
seed_in  in  WIDE_W  seed value
start  in  1  begin run (honoured only in IDLE)
num_vectors  in  CNT_W  vectors per run, sampled at start
out_small  out  SMALL_W  to downstream in_small
out_quad  out  QUAD_W  to downstream in_quad
out_wide  out  WIDE_W  to downstream in_wide
vec_valid  out  1  out_* carry a new vector this cycle
ret_small  in  SMALL_W  from downstream out_small
ret_quad  in  QUAD_W  from downstream out_quad
ret_wide  in  WIDE_W  from downstream out_wide
busy  out  1  state is RUN or DRAIN
done  out  1  one-cycle pulse at end of run
mismatch  out  1  sticky: any compare failed this run
err_count  out  CNT_W  failing vectors this run (see Optional Feature)

Behaviour:
- Reset (reset=1 at clk edge, including mid-run): state IDLE; LFSR=SEED; out_*=0; vec_valid=0; busy=0; done=0; mismatch=0; err_count=0; expected-pipeline valid bits cleared.
- LFSR: Fibonacci, taps 70,69,55,54: fb = s[69]^s[68]^s[54]^s[53]; next s = {s[68:0], fb}. Advances only when a vector is issued.
- Lanes: out_wide = s; out_quad = s[QUAD_W-1:0]; out_small = s[SMALL_W-1:0]. All registered.
- seed_load in IDLE: LFSR <= seed_in; if seed_in==0, LFSR <= SEED (avoid lock-up). Ignored outside IDLE. seed_load and start in the same cycle: seed loaded, start ignored.
- FSM IDLE/RUN/DRAIN/DONE:
  IDLE: start with num_vectors>0 -> RUN; clear mismatch and err_count; latch count. start with num_vectors==0 -> DONE, with no vectors issued.
  RUN: each cycle registers current LFSR to out_*, vec_valid=1, advances LFSR, decrements count; after last vector -> DRAIN. Exactly num_vectors cycles with vec_valid=1, back to back.
  DRAIN: LAT cycles, vec_valid=0, out_* hold last value; then -> DONE.
  DONE: done=1 for one cycle -> IDLE.
- start while busy: ignored.
- Checking: a LAT-deep shift pipeline of {valid, expected wide value} follows vec_valid/out_wide. When the pipeline tail is valid, compare ret_wide vs expected, ret_quad vs expected[QUAD_W-1:0], and ret_small vs expected[SMALL_W-1:0]. Any lane differing is one failing vector: set mismatch (held until next accepted start or reset). The last compare happens in the final DRAIN cycle, so mismatch is final when done=1.
- LFSR state persists across runs. A new run without seed_load continues the sequence.

Optional Feature:
Macro VEC_STIM_ERR_CNT_EN. Defined: err_count increments by 1 per failing vector and saturates at all-ones; it is cleared on accepted start. Undefined: err_count tied to 0 and the counter is not built; mismatch behaviour is unchanged.

Test Plan:
- Reset then seed_load seed_in=70'h1, start num_vectors=3, ret_*=out_* delayed 1 cycle -> out_wide 70'h1, 70'h2, 70'h4 on 3 vec_valid cycles; done 1 cycle after DRAIN; mismatch=0; err_count=0.
- seed_load seed_in=0 -> first vector out_wide==SEED.
- num_vectors=4, force ret_small to bit-flipped value on 2nd returned vector only -> mismatch=1 at done, err_count=1 (with macro) / 0 (without).
- start num_vectors=0 -> no vec_valid; done pulses on the cycle after start; busy stays 0.
- Assert reset during RUN after 2 of 10 vectors -> next cycle all outputs at reset values; a following start without seed reissues sequence from SEED.
- start pulsed at RUN cycle 3 of num_vectors=5 -> still exactly 5 vectors and a single done pulse.
